// File: rtl/pwm_pkg.sv
// Shared helpers for the PWM serializer word generator: width derivation
// and the level a channel parks at while the generator is idle.
package pwm_pkg;

    // Number of bit-index bits inside one serializer word.
    function automatic int serw_of(input int ser);
        return $clog2(ser);
    endfunction

    // Duty field width: integer bit position (period words + bit index) plus fraction.
    function automatic int cmpw_of(input int perw, input int ser, input int fracw);
        return perw + $clog2(ser) + fracw;
    endfunction

    // Level of every bit of the idle word: the line rests at its inactive
    // level, which is low unless the channel is inverted.
    function automatic logic idle_level(input logic inv);
        return inv;
    endfunction

endpackage

// File: rtl/pwm_serdes_chan.sv
// One PWM channel: active duty/polarity, first-order dither accumulator and
// the SER-wide parallel compare that builds the next serializer word.
module pwm_serdes_chan
    import pwm_pkg::*;
#(
    parameter int  SER   = 8,
    parameter int  PERW  = 4,
    parameter int  FRACW = 4,
    localparam int SERW  = serw_of(SER),
    localparam int CMPW  = cmpw_of(PERW, SER, FRACW),
    localparam int IW    = PERW + SERW
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en,
    input  logic            start,
    input  logic            load,
    input  logic [PERW-1:0] cnt,
    input  logic [PERW-1:0] per_act,
    input  logic [CMPW-1:0] new_cmp,
    input  logic            new_inv,
    output logic [SER-1:0]  word
);

    typedef struct packed {
        logic [CMPW-1:0] cmp;
        logic            inv;
    } chan_cfg_t;

    chan_cfg_t        cfg_reg;
    chan_cfg_t        cfg_cur;
    logic [FRACW-1:0] acc_reg;
    logic             carry_reg;
    logic [FRACW:0]   acc_sum;
    logic             carry_cur;
    logic [IW:0]      duty;
    logic [IW:0]      period_bits;
    logic [IW:0]      limit;
    logic [SER-1:0]   word_next;
    logic [SER-1:0]   word_reg;

    // Effective duty for the word built this cycle. A load landing on a
    // period start (or while idle) takes effect immediately, so the dither
    // step of that start already uses the new fraction.
    always_comb begin
        cfg_cur = cfg_reg;
        if (load && (start || !en)) begin
            cfg_cur = '{cmp: new_cmp, inv: new_inv};
        end
        acc_sum     = {1'b0, acc_reg} + {1'b0, cfg_cur.cmp[FRACW-1:0]};
        carry_cur   = start ? acc_sum[FRACW] : carry_reg;
        duty        = {1'b0, cfg_cur.cmp[CMPW-1:FRACW]} + {{IW{1'b0}}, carry_cur};
        period_bits = {({1'b0, per_act} + 1'b1), {SERW{1'b0}}};
        limit       = (duty < period_bits) ? duty : period_bits;
    end

    // Bit gi of the word is fast-bit position cnt*SER+gi of the period.
    for (genvar gi = 0; gi < SER; gi++) begin : g_bit
        assign word_next[gi] = en ? (({1'b0, cnt, SERW'(gi)} < limit) ^ cfg_cur.inv)
                                  : idle_level(cfg_cur.inv);
    end

    // Active config, dither state and the registered output word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_reg   <= '0;
            acc_reg   <= '0;
            carry_reg <= 1'b0;
            word_reg  <= '0;
        end else begin
            if (load) begin
                cfg_reg <= '{cmp: new_cmp, inv: new_inv};
            end
            if (!en) begin
                acc_reg   <= '0;
                carry_reg <= 1'b0;
            end else if (start) begin
                acc_reg   <= acc_sum[FRACW-1:0];
                carry_reg <= acc_sum[FRACW];
            end
            word_reg <= word_next;
        end
    end

    assign word = word_reg;

endmodule

// File: rtl/pwm_serdes_gen.sv
// Multi-channel PWM word generator for SER:1 output serializers. Holds the
// word counter, the one-deep config shadow with its handshake, and the
// period-start flag; the per-channel words come from pwm_serdes_chan.
module pwm_serdes_gen
    import pwm_pkg::*;
#(
    parameter int  NCH     = 2,
    parameter int  SER     = 8,
    parameter int  PERW    = 4,
    parameter int  FRACW   = 4,
    parameter int  PER_RST = 3,
    localparam int CMPW    = cmpw_of(PERW, SER, FRACW)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [PERW-1:0]     cfg_per,
    input  logic [NCH*CMPW-1:0] cfg_cmp,
    input  logic [NCH-1:0]      cfg_inv,
    output logic [NCH*SER-1:0]  pwm_d,
    output logic                per_start
);

    logic [PERW-1:0]     cnt_reg;
    logic [PERW-1:0]     per_act_reg;
    logic                sh_full_reg;
    logic [PERW-1:0]     sh_per_reg;
    logic [NCH*CMPW-1:0] sh_cmp_reg;
    logic [NCH-1:0]      sh_inv_reg;
    logic                per_start_reg;

    logic                start;
    logic                wrap;
    logic                load;
    logic                accept;
    logic [PERW-1:0]     per_word;

    // Period boundaries and shadow transfer. The shadow only becomes full
    // after its acceptance edge, so a config taken on a wrap cycle waits for
    // the following wrap. While idle the shadow is applied at once.
    always_comb begin
        start    = en && (cnt_reg == '0);
        wrap     = en && (cnt_reg == per_act_reg);
        load     = sh_full_reg && (wrap || !en);
        accept   = cfg_valid && !sh_full_reg;
        per_word = (load && start) ? sh_per_reg : per_act_reg;
    end

    assign cfg_ready = !sh_full_reg;

    // Shadow register: capture on handshake, empty on transfer to active.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_full_reg <= 1'b0;
            sh_per_reg  <= '0;
            sh_cmp_reg  <= '0;
            sh_inv_reg  <= '0;
        end else if (accept) begin
            sh_full_reg <= 1'b1;
            sh_per_reg  <= cfg_per;
            sh_cmp_reg  <= cfg_cmp;
            sh_inv_reg  <= cfg_inv;
        end else if (load) begin
            sh_full_reg <= 1'b0;
        end
    end

    // Word counter, active period and the registered period-start flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg       <= '0;
            per_act_reg   <= PERW'(PER_RST);
            per_start_reg <= 1'b0;
        end else begin
            if (load) begin
                per_act_reg <= sh_per_reg;
            end
            if (!en || wrap) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            per_start_reg <= start;
        end
    end

    assign per_start = per_start_reg;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        pwm_serdes_chan #(
            .SER   (SER),
            .PERW  (PERW),
            .FRACW (FRACW)
        ) u_chan (
            .clk     (clk),
            .rst_n   (rst_n),
            .en      (en),
            .start   (start),
            .load    (load),
            .cnt     (cnt_reg),
            .per_act (per_word),
            .new_cmp (sh_cmp_reg[gi*CMPW +: CMPW]),
            .new_inv (sh_inv_reg[gi]),
            .word    (pwm_d[gi*SER +: SER])
        );
    end

endmodule
